// File: rtl/timer_pkg.sv
//------------------------------------------------------------------------------
// timer_pkg: shared types, constants and BCD helpers for the MM:SS timer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef logic [3:0] digit_t;

    localparam digit_t BCD_MAX_SEC_TENS = 4'd5;

    // Divider terminal count; simulations scale clk_div down from this.
    localparam int DIV_COUNT = 50_000_000;

    function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
        digit_t tens;
        digit_t ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones == 4'd9) begin
            tens = tens + 4'd1;
            ones = 4'd0;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

    function automatic logic [7:0] bcd2_dec(input logic [7:0] v);
        digit_t tens;
        digit_t ones;
        tens = v[7:4];
        ones = v[3:0];
        if (ones == 4'd0) begin
            tens = tens - 4'd1;
            ones = 4'd9;
        end else begin
            ones = ones - 4'd1;
        end
        return {tens, ones};
    endfunction

    function automatic logic digit_ok(input digit_t d);
        return d <= 4'd9;
    endfunction

    function automatic logic sec_ok(input logic [7:0] s);
        return (s[7:4] <= BCD_MAX_SEC_TENS) && digit_ok(s[3:0]);
    endfunction

    function automatic logic min_ok(input logic [7:0] m, input logic [7:0] max_m);
        return digit_ok(m[7:4]) && digit_ok(m[3:0]) && (m <= max_m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_sec_timer_if.sv
//------------------------------------------------------------------------------
// bcd_sec_timer_if: control, preset and display signals of the MM:SS timer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface bcd_sec_timer_if;

    logic       clk_div_in;
    logic       start;
    logic       stop;
    logic       clear;
    logic       load;
    logic       dir;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       expired;
    logic       wrap;
    logic       load_err;
    logic       tick;

    modport master (
        output clk_div_in, start, stop, clear, load, dir, load_min, load_sec,
        input  min_bcd, sec_bcd, running, expired, wrap, load_err, tick
    );

    modport slave (
        input  clk_div_in, start, stop, clear, load, dir, load_min, load_sec,
        output min_bcd, sec_bcd, running, expired, wrap, load_err, tick
    );

endinterface

`default_nettype wire

// File: rtl/edge_tick_sync.sv
//------------------------------------------------------------------------------
// edge_tick_sync: flop-chain synchroniser with a one-cycle rising-edge pulse.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module edge_tick_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic din,
    output logic      pulse
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[STAGES-2:0], din};
            prev <= sync[STAGES-1];
        end
    end

    // Combinational so the pulse coincides with the first synchronised high.
    assign pulse = sync[STAGES-1] & ~prev;

endmodule

`default_nettype wire

// File: rtl/bcd_sec_timer.sv
//------------------------------------------------------------------------------
// bcd_sec_timer: BCD MM:SS up/down timer advanced by rising edges of clk_div.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bcd_sec_timer
    import timer_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] MAX_MIN_BCD = 8'h59
) (
    input  wire logic       clk,
    input  wire logic       rst,
    bcd_sec_timer_if.slave  bus
);

    state_t     state;
    logic [7:0] cnt_min;
    logic [7:0] cnt_sec;
    logic       run_dir;
    logic       running;
    logic       expired;
    logic       wrap;
    logic       load_err;
    logic       tick;

    logic [7:0] up_min;
    logic [7:0] up_sec;
    logic       up_wrap;
    logic [7:0] dn_min;
    logic [7:0] dn_sec;
    logic       cnt_zero;
    logic       dn_zero;
    logic       load_valid;

    edge_tick_sync #(
        .STAGES (SYNC_STAGES)
    ) u_tick_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (bus.clk_div_in),
        .pulse (tick)
    );

    always_comb begin
        up_wrap = 1'b0;
        up_min  = cnt_min;
        up_sec  = bcd2_inc(cnt_sec);
        if (cnt_sec == {BCD_MAX_SEC_TENS, 4'd9}) begin
            up_sec = 8'h00;
            if (cnt_min == MAX_MIN_BCD) begin
                up_min  = 8'h00;
                up_wrap = 1'b1;
            end else begin
                up_min = bcd2_inc(cnt_min);
            end
        end

        dn_min = cnt_min;
        dn_sec = bcd2_dec(cnt_sec);
        if (cnt_sec == 8'h00) begin
            dn_sec = {BCD_MAX_SEC_TENS, 4'd9};
            dn_min = bcd2_dec(cnt_min);
        end
    end

    assign cnt_zero   = (cnt_min == 8'h00) && (cnt_sec == 8'h00);
    assign dn_zero    = (dn_min == 8'h00) && (dn_sec == 8'h00);
    assign load_valid = sec_ok(bus.load_sec) && min_ok(bus.load_min, MAX_MIN_BCD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt_min  <= 8'h00;
            cnt_sec  <= 8'h00;
            run_dir  <= 1'b0;
            running  <= 1'b0;
            expired  <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (bus.clear) begin
                cnt_min <= 8'h00;
                cnt_sec <= 8'h00;
                expired <= 1'b0;
                state   <= ST_IDLE;
                running <= 1'b0;
            end else if (bus.load) begin
                if (load_valid) begin
                    cnt_min <= bus.load_min;
                    cnt_sec <= bus.load_sec;
                    expired <= 1'b0;
                    state   <= ST_IDLE;
                    running <= 1'b0;
                end else begin
                    load_err <= 1'b1;
                end
            end else if (bus.stop) begin
                if (state == ST_RUN) begin
                    state   <= ST_PAUSE;
                    running <= 1'b0;
                end
            end else if (bus.start && (state == ST_IDLE || state == ST_PAUSE)) begin
                run_dir <= bus.dir;
                // Down-start from 00:00 has nothing to count.
                if (bus.dir && cnt_zero && state == ST_IDLE) begin
                    state   <= ST_DONE;
                    expired <= 1'b1;
                    running <= 1'b0;
                end else begin
                    state   <= ST_RUN;
                    running <= 1'b1;
                end
            end else if (tick && state == ST_RUN) begin
                if (!run_dir) begin
                    cnt_min <= up_min;
                    cnt_sec <= up_sec;
                    wrap    <= up_wrap;
                end else if (cnt_zero) begin
                    // Resumed downward at 00:00 after an up-count wrap.
                    state   <= ST_DONE;
                    expired <= 1'b1;
                    running <= 1'b0;
                end else begin
                    cnt_min <= dn_min;
                    cnt_sec <= dn_sec;
                    if (dn_zero) begin
                        state   <= ST_DONE;
                        expired <= 1'b1;
                        running <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.min_bcd  = cnt_min;
    assign bus.sec_bcd  = cnt_sec;
    assign bus.running  = running;
    assign bus.expired  = expired;
    assign bus.wrap     = wrap;
    assign bus.load_err = load_err;
    assign bus.tick     = tick;

endmodule

`default_nettype wire

// File: tb/tb_bcd_sec_timer.sv
//------------------------------------------------------------------------------
// tb_bcd_sec_timer: directed self-checking bench for the BCD MM:SS timer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bcd_sec_timer;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    bcd_sec_timer_if bus ();

    bcd_sec_timer #(
        .SYNC_STAGES (2),
        .MAX_MIN_BCD (8'h59)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [7:0] m, input logic [7:0] s);
        chk(tag, {16'h0, bus.min_bcd, bus.sec_bcd}, {16'h0, m, s});
    endtask

    task automatic do_load(input logic [7:0] m, input logic [7:0] s);
        bus.load_min = m;
        bus.load_sec = s;
        bus.load     = 1'b1;
        step();
        bus.load     = 1'b0;
    endtask

    task automatic do_start(input logic d);
        bus.dir   = d;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
    endtask

    // Raise clk_div and return just after the edge that applies the tick.
    task automatic tick_edge();
        bus.clk_div_in = 1'b1;
        repeat (3) step();
    endtask

    task automatic tick_low();
        bus.clk_div_in = 1'b0;
        repeat (3) step();
    endtask

    task automatic tick_once();
        tick_edge();
        tick_low();
    endtask

    initial begin
        $display("bench: clk_div scaled down from a %0d-cycle half period", DIV_COUNT);
        rst            = 1'b1;
        bus.clk_div_in = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.clear      = 1'b0;
        bus.load       = 1'b0;
        bus.dir        = 1'b0;
        bus.load_min   = 8'h00;
        bus.load_sec   = 8'h00;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk_cnt("rst_count", 8'h00, 8'h00);
        chk("rst_flags", {27'h0, bus.running, bus.expired, bus.wrap, bus.load_err, bus.tick}, 32'h0);

        // Synchroniser latency
        do_load(8'h00, 8'h00);
        do_start(1'b0);
        chk("run_after_start", {31'h0, bus.running}, 32'h1);
        bus.clk_div_in = 1'b1;
        step();
        chk("tick_edge1", {31'h0, bus.tick}, 32'h0);
        step();
        chk("tick_edge2", {31'h0, bus.tick}, 32'h1);
        chk_cnt("cnt_before_tick", 8'h00, 8'h00);
        step();
        chk("tick_edge3", {31'h0, bus.tick}, 32'h0);
        chk_cnt("cnt_after_tick", 8'h00, 8'h01);
        tick_low();

        // Up-count wrap at 59:59
        do_load(8'h59, 8'h58);
        chk("idle_after_load", {31'h0, bus.running}, 32'h0);
        do_start(1'b0);
        tick_once();
        chk_cnt("up_5959", 8'h59, 8'h59);
        chk("no_wrap_yet", {31'h0, bus.wrap}, 32'h0);
        tick_edge();
        chk_cnt("up_wrap_0000", 8'h00, 8'h00);
        chk("wrap_pulse", {31'h0, bus.wrap}, 32'h1);
        chk("wrap_running", {31'h0, bus.running}, 32'h1);
        tick_low();
        chk("wrap_one_cycle", {31'h0, bus.wrap}, 32'h0);
        tick_once();
        chk_cnt("up_after_wrap", 8'h00, 8'h01);

        // Down-count expiry from 01:00
        do_load(8'h01, 8'h00);
        do_start(1'b1);
        tick_once();
        chk_cnt("dn_0059", 8'h00, 8'h59);
        for (int i = 0; i < 58; i++) tick_once();
        chk_cnt("dn_0001", 8'h00, 8'h01);
        chk("dn_not_expired", {31'h0, bus.expired}, 32'h0);
        tick_edge();
        chk_cnt("dn_0000", 8'h00, 8'h00);
        chk("dn_expired", {31'h0, bus.expired}, 32'h1);
        chk("dn_done_stopped", {31'h0, bus.running}, 32'h0);
        tick_low();
        tick_once();
        chk_cnt("done_holds", 8'h00, 8'h00);
        chk("done_sticky", {31'h0, bus.expired}, 32'h1);
        do_start(1'b0);
        chk("done_ignores_start", {31'h0, bus.running}, 32'h0);
        do_clear();
        chk("clear_expired", {31'h0, bus.expired}, 32'h0);
        chk("clear_idle", {31'h0, bus.running}, 32'h0);

        // Down-start at 00:00 expires without a tick
        do_start(1'b1);
        chk("zero_dn_start_exp", {31'h0, bus.expired}, 32'h1);
        chk("zero_dn_start_run", {31'h0, bus.running}, 32'h0);
        do_clear();

        // Priority: stop beats a coincident tick
        do_load(8'h00, 8'h06);
        do_start(1'b0);
        tick_once();
        chk_cnt("prio_0007", 8'h00, 8'h07);
        bus.clk_div_in = 1'b1;
        step();
        step();
        chk("prio_tick_live", {31'h0, bus.tick}, 32'h1);
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk_cnt("stop_drops_tick", 8'h00, 8'h07);
        chk("stop_paused", {31'h0, bus.running}, 32'h0);
        tick_low();
        tick_once();
        chk_cnt("pause_holds", 8'h00, 8'h07);
        bus.load_min = 8'h12;
        bus.load_sec = 8'h34;
        bus.clear    = 1'b1;
        bus.load     = 1'b1;
        bus.start    = 1'b1;
        step();
        bus.clear    = 1'b0;
        bus.load     = 1'b0;
        bus.start    = 1'b0;
        chk_cnt("clear_wins", 8'h00, 8'h00);
        chk("clear_wins_idle", {31'h0, bus.running}, 32'h0);
        tick_once();
        chk_cnt("idle_no_count", 8'h00, 8'h00);

        // Invalid loads
        do_load(8'h12, 8'h6A);
        chk("bad_sec_err", {31'h0, bus.load_err}, 32'h1);
        chk_cnt("bad_sec_keep", 8'h00, 8'h00);
        step();
        chk("bad_err_pulse", {31'h0, bus.load_err}, 32'h0);
        do_load(8'h60, 8'h00);
        chk("bad_min_range", {31'h0, bus.load_err}, 32'h1);
        do_load(8'h1A, 8'h00);
        chk("bad_min_nibble", {31'h0, bus.load_err}, 32'h1);
        chk_cnt("bad_min_keep", 8'h00, 8'h00);
        do_load(8'h12, 8'h34);
        chk("good_load_noerr", {31'h0, bus.load_err}, 32'h0);
        chk_cnt("good_load", 8'h12, 8'h34);

        // Mid-run reset coincident with a tick
        do_load(8'h03, 8'h14);
        do_start(1'b0);
        tick_once();
        chk_cnt("pre_rst_0315", 8'h03, 8'h15);
        bus.clk_div_in = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cnt("midrst_count", 8'h00, 8'h00);
        chk("midrst_flags", {27'h0, bus.running, bus.expired, bus.wrap, bus.load_err, bus.tick}, 32'h0);
        tick_low();
        tick_once();
        chk_cnt("midrst_idle", 8'h00, 8'h00);
        do_start(1'b0);
        tick_once();
        chk_cnt("restart_count", 8'h00, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
